axi_lite_slave: RTL and testbench

- AXI-Lite responder. Terminates all five channels driven by AXI_Master and backs them with a register bank of NUM_REGS x DATA_W registers.
- Read and write paths are independent. AW and W are accepted independently and joined before the write commits.
- Out-of-range addresses return SLVERR and never modify storage.

---
 rtl/axi_lite_slave_pkg.sv | 24 ++
 rtl/axi_lite_slave_if.sv | 36 +++
 rtl/axi_lite_regfile.sv | 32 +++
 rtl/axi_lite_slave.sv | 113 +++++++++++
 tb/tb_axi_lite_slave.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_slave_pkg.sv
// Purpose: shared widths, bus payload types, response codes and the address
//          range helper for the AXI-Lite register slave.
// Contents: ADDR_W/DATA_W/RESP_W widths, DEF_NUM_REGS default bank depth,
//           addr_t/data_t/resp_t, RESP_OKAY/RESP_SLVERR, addr_in_range().
package axi_lite_slave_pkg;

  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned RESP_W       = 4;
  localparam int unsigned DEF_NUM_REGS = 12;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [RESP_W-1:0] resp_t;

  localparam resp_t RESP_OKAY   = 4'b0000;
  localparam resp_t RESP_SLVERR = 4'b0010;

  // True when the address maps onto an implemented register.
  function automatic logic addr_in_range(input addr_t addr, input int unsigned num_regs);
    return 32'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// Purpose: AXI-Lite five-channel bundle between a master and the register slave.
// Signals: AR (read_address, AR_VALID, AR_READY), R (data_read, R_VALID, R_READY),
//          AW (write_address, AW_VALID, AW_READY), W (data_write, W_VALID, W_READY),
//          B (B_VALID, BRESPONSE, B_READY).
interface axi_lite_slave_if;
  import axi_lite_slave_pkg::*;

  addr_t read_address;
  logic  AR_VALID;
  logic  AR_READY;
  data_t data_read;
  logic  R_VALID;
  logic  R_READY;
  addr_t write_address;
  logic  AW_VALID;
  logic  AW_READY;
  data_t data_write;
  logic  W_VALID;
  logic  W_READY;
  logic  B_VALID;
  resp_t BRESPONSE;
  logic  B_READY;

  modport master (
    output read_address, AR_VALID, R_READY,
    output write_address, AW_VALID, data_write, W_VALID, B_READY,
    input  AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID, BRESPONSE
  );

  modport slave (
    input  read_address, AR_VALID, R_READY,
    input  write_address, AW_VALID, data_write, W_VALID, B_READY,
    output AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID, BRESPONSE
  );

endinterface

// File: rtl/axi_lite_regfile.sv
// Purpose: NUM_REGS x DATA_W register bank, one synchronous write port and one
//          asynchronous read port, cleared by asynchronous reset.
// Ports: clk, rst (async, active-high), i_we/i_waddr/i_wdata (write port),
//        i_raddr/o_rdata_c (combinational read port; caller qualifies range).
module axi_lite_regfile
  import axi_lite_slave_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_we,
  input  addr_t i_waddr,
  input  data_t i_wdata,
  input  addr_t i_raddr,
  output data_t o_rdata_c
);

  data_t r_mem [NUM_REGS];

  // Storage: cleared on reset, written only when the caller asserts i_we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/axi_lite_slave.sv
// Purpose: AXI-Lite responder backed by a NUM_REGS-deep register bank.
//          Read and write paths are independent; AW and W are buffered
//          separately and joined into a single commit. Out-of-range accesses
//          read as 0 / respond SLVERR and never touch storage.
// Ports: clk, rst (async, active-high), bus (axi_lite_slave_if.slave).
module axi_lite_slave
  import axi_lite_slave_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  axi_lite_slave_if.slave   bus
);

  logic  r_r_valid;
  data_t r_data_read;
  logic  r_aw_full;
  addr_t r_aw_addr;
  logic  r_w_full;
  data_t r_w_data;
  logic  r_b_valid;
  resp_t r_bresp;

  logic  w_ar_hs;
  logic  w_aw_hs;
  logic  w_w_hs;
  logic  w_commit;
  logic  w_aw_in_range;
  logic  w_ar_in_range;
  data_t w_rdata;

  // READY terms come from flops only, so no VALID-to-READY combinational path.
  assign w_ar_hs  = bus.AR_VALID && !r_r_valid;
  assign w_aw_hs  = bus.AW_VALID && !r_aw_full;
  assign w_w_hs   = bus.W_VALID  && !r_w_full;
  // Commit waits for the previous response to retire so B is never overwritten.
  assign w_commit = r_aw_full && r_w_full && !r_b_valid;

  assign w_aw_in_range = addr_in_range(r_aw_addr, NUM_REGS);
  assign w_ar_in_range = addr_in_range(bus.read_address, NUM_REGS);

  axi_lite_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_commit && w_aw_in_range),
    .i_waddr   (r_aw_addr),
    .i_wdata   (r_w_data),
    .i_raddr   (bus.read_address),
    .o_rdata_c (w_rdata)
  );

  // Read channel: capture on AR handshake, hold until R retires.
  // A same-edge commit is not yet visible on the async port, so reads see old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r_valid   <= 1'b0;
      r_data_read <= '0;
    end else if (w_ar_hs) begin
      r_r_valid   <= 1'b1;
      r_data_read <= w_ar_in_range ? w_rdata : '0;
    end else if (r_r_valid && bus.R_READY) begin
      r_r_valid   <= 1'b0;
      r_data_read <= '0;
    end
  end

  // Write address / data buffers: each fills on its handshake, both drain on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= bus.write_address;
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= bus.data_write;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end
    end
  end

  // Write response: raised by commit, held until B handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else if (w_commit) begin
      r_b_valid <= 1'b1;
      r_bresp   <= w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_b_valid && bus.B_READY) begin
      r_b_valid <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end
  end

  assign bus.AR_READY  = !r_r_valid;
  assign bus.R_VALID   = r_r_valid;
  assign bus.data_read = r_data_read;
  assign bus.AW_READY  = !r_aw_full;
  assign bus.W_READY   = !r_w_full;
  assign bus.B_VALID   = r_b_valid;
  assign bus.BRESPONSE = r_bresp;

endmodule

// File: tb/tb_axi_lite_slave.sv
// Purpose: directed self-checking bench for axi_lite_slave.
module tb_axi_lite_slave;
  import axi_lite_slave_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  axi_lite_slave_if bus ();

  axi_lite_slave #(.NUM_REGS(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single read with R_READY high: data one cycle after AR, retired the next edge.
  task automatic do_read(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    bus.R_READY      = 1'b1;
    bus.read_address = addr;
    bus.AR_VALID     = 1'b1;
    tick();
    bus.AR_VALID = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus.R_VALID), 32'd1);
    chk({tag, "_rdata"}, 32'(bus.data_read), 32'(exp));
    tick();
    chk({tag, "_rvalid_clr"}, 32'(bus.R_VALID), 32'd0);
  endtask

  // Write with AW and W together and B_READY high.
  task automatic do_write(input string tag, input logic [3:0] addr, input logic [7:0] data,
                          input logic [3:0] exp_resp);
    bus.B_READY       = 1'b1;
    bus.write_address = addr;
    bus.data_write    = data;
    bus.AW_VALID      = 1'b1;
    bus.W_VALID       = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    chk({tag, "_bvalid_n"}, 32'(bus.B_VALID), 32'd0);
    tick();
    chk({tag, "_bvalid"}, 32'(bus.B_VALID), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.BRESPONSE), 32'(exp_resp));
    tick();
    chk({tag, "_bvalid_clr"}, 32'(bus.B_VALID), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_mem [12];
    checks = 0;
    errors = 0;
    for (int i = 0; i < 12; i++) exp_mem[i] = 8'h00;
    rst               = 1'b1;
    bus.read_address  = '0;
    bus.AR_VALID      = 1'b0;
    bus.R_READY       = 1'b0;
    bus.write_address = '0;
    bus.AW_VALID      = 1'b0;
    bus.data_write    = '0;
    bus.W_VALID       = 1'b0;
    bus.B_READY       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_arready", 32'(bus.AR_READY), 32'd1);
    chk("rst_awready", 32'(bus.AW_READY), 32'd1);
    chk("rst_wready",  32'(bus.W_READY),  32'd1);
    chk("rst_rvalid",  32'(bus.R_VALID),  32'd0);
    chk("rst_rdata",   32'(bus.data_read), 32'd0);
    chk("rst_bvalid",  32'(bus.B_VALID),  32'd0);
    chk("rst_bresp",   32'(bus.BRESPONSE), 32'd0);

    // AW=3/W=A5 together, then read back with R_READY low for one cycle
    do_write("w3", 4'd3, 8'hA5, 4'b0000);
    exp_mem[3] = 8'hA5;
    bus.R_READY      = 1'b0;
    bus.read_address = 4'd3;
    bus.AR_VALID     = 1'b1;
    tick();
    bus.AR_VALID = 1'b0;
    chk("r3_rvalid", 32'(bus.R_VALID), 32'd1);
    chk("r3_rdata", 32'(bus.data_read), 32'hA5);
    chk("r3_arready", 32'(bus.AR_READY), 32'd0);
    bus.R_READY = 1'b1;
    tick();
    chk("r3_rvalid_clr", 32'(bus.R_VALID), 32'd0);
    chk("r3_rdata_clr", 32'(bus.data_read), 32'd0);

    // W ahead of AW by four cycles
    bus.B_READY    = 1'b1;
    bus.data_write = 8'h3C;
    bus.W_VALID    = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("w_first_wready", 32'(bus.W_READY), 32'd0);
      chk("w_first_awready", 32'(bus.AW_READY), 32'd1);
      chk("w_first_bvalid", 32'(bus.B_VALID), 32'd0);
      tick();
    end
    bus.write_address = 4'd5;
    bus.AW_VALID      = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    chk("w_first_wait_commit", 32'(bus.B_VALID), 32'd0);
    chk("w_first_wready_hold", 32'(bus.W_READY), 32'd0);
    tick();
    chk("w_first_bvalid1", 32'(bus.B_VALID), 32'd1);
    chk("w_first_bresp", 32'(bus.BRESPONSE), 32'd0);
    chk("w_first_wready_back", 32'(bus.W_READY), 32'd1);
    tick();
    chk("w_first_single", 32'(bus.B_VALID), 32'd0);
    exp_mem[5] = 8'h3C;
    do_read("r5", 4'd5, 8'h3C);

    // Out-of-range write and read
    do_write("wE", 4'hE, 8'hFF, 4'b0010);
    do_read("rE", 4'hE, 8'h00);
    for (int i = 0; i < 12; i++) do_read($sformatf("scan%0d", i), 4'(i), exp_mem[i]);

    // B backpressure with a second AW/W buffered behind it
    bus.B_READY       = 1'b0;
    bus.write_address = 4'd7;
    bus.data_write    = 8'h11;
    bus.AW_VALID      = 1'b1;
    bus.W_VALID       = 1'b1;
    tick();
    bus.write_address = 4'd8;
    bus.data_write    = 8'h22;
    tick();
    chk("bp_bvalid", 32'(bus.B_VALID), 32'd1);
    chk("bp_awready_open", 32'(bus.AW_READY), 32'd1);
    tick();
    bus.AW_VALID = 1'b0;
    bus.W_VALID  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid_hold", 32'(bus.B_VALID), 32'd1);
      chk("bp_bresp_hold", 32'(bus.BRESPONSE), 32'd0);
      chk("bp_awready", 32'(bus.AW_READY), 32'd0);
      chk("bp_wready", 32'(bus.W_READY), 32'd0);
      tick();
    end
    bus.B_READY = 1'b1;
    tick();
    chk("bp_b_retired", 32'(bus.B_VALID), 32'd0);
    chk("bp_no_early_commit", 32'(bus.AW_READY), 32'd0);
    tick();
    chk("bp_second_bvalid", 32'(bus.B_VALID), 32'd1);
    chk("bp_second_awready", 32'(bus.AW_READY), 32'd1);
    tick();
    chk("bp_second_retired", 32'(bus.B_VALID), 32'd0);
    exp_mem[7] = 8'h11;
    exp_mem[8] = 8'h22;
    do_read("r7", 4'd7, 8'h11);
    do_read("r8", 4'd8, 8'h22);

    // R backpressure with a pending AR for another address
    bus.R_READY      = 1'b0;
    bus.read_address = 4'd3;
    bus.AR_VALID     = 1'b1;
    tick();
    bus.read_address = 4'd5;
    for (int i = 0; i < 4; i++) begin
      chk("rbp_rvalid", 32'(bus.R_VALID), 32'd1);
      chk("rbp_rdata", 32'(bus.data_read), 32'hA5);
      chk("rbp_arready", 32'(bus.AR_READY), 32'd0);
      tick();
    end
    bus.R_READY = 1'b1;
    tick();
    chk("rbp_retired", 32'(bus.R_VALID), 32'd0);
    tick();
    bus.AR_VALID = 1'b0;
    chk("rbp_second_rvalid", 32'(bus.R_VALID), 32'd1);
    chk("rbp_second_rdata", 32'(bus.data_read), 32'h3C);
    tick();
    chk("rbp_second_retired", 32'(bus.R_VALID), 32'd0);

    // Read captured on the commit edge of the same address sees the old value
    bus.write_address = 4'd2;
    bus.data_write    = 8'h5A;
    bus.AW_VALID      = 1'b1;
    bus.W_VALID       = 1'b1;
    tick();
    bus.AW_VALID     = 1'b0;
    bus.W_VALID      = 1'b0;
    bus.read_address = 4'd2;
    bus.AR_VALID     = 1'b1;
    tick();
    bus.AR_VALID = 1'b0;
    chk("raw_bvalid", 32'(bus.B_VALID), 32'd1);
    chk("raw_old_data", 32'(bus.data_read), 32'h00);
    tick();
    exp_mem[2] = 8'h5A;
    do_read("raw_new", 4'd2, 8'h5A);

    // Reset with AW buffered and W outstanding
    bus.write_address = 4'd9;
    bus.AW_VALID      = 1'b1;
    bus.R_READY       = 1'b0;
    bus.read_address  = 4'd3;
    bus.AR_VALID      = 1'b1;
    tick();
    bus.AW_VALID = 1'b0;
    bus.AR_VALID = 1'b0;
    chk("mid_awready", 32'(bus.AW_READY), 32'd0);
    chk("mid_rvalid", 32'(bus.R_VALID), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", 32'(bus.R_VALID), 32'd0);
    chk("mid_rst_bvalid", 32'(bus.B_VALID), 32'd0);
    chk("mid_rst_awready", 32'(bus.AW_READY), 32'd1);
    chk("mid_rst_wready", 32'(bus.W_READY), 32'd1);
    chk("mid_rst_rdata", 32'(bus.data_read), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) exp_mem[i] = 8'h00;
    tick();
    bus.data_write = 8'h44;
    bus.W_VALID    = 1'b1;
    bus.B_READY    = 1'b1;
    tick();
    bus.W_VALID = 1'b0;
    tick();
    chk("post_rst_no_commit", 32'(bus.B_VALID), 32'd0);
    do_read("post_rst_r9", 4'd9, 8'h00);
    do_read("post_rst_r3", 4'd3, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
